// File: rtl/axi_llc_sram_banked.sv
// Word-interleaved banked SRAM with an in-order read response buffer and a zero-init sequencer.
// Reads return Latency cycles after acceptance; writes are posted and produce no response.

module tc_sram #(
    parameter int unsigned NumWords  = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 2,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                 clk_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic [DataWidth-1:0] rdata_o
);
    logic [DataWidth-1:0] mem_q   [NumWords];
    logic [DataWidth-1:0] rdata_q [Latency];
    logic [DataWidth-1:0] bit_mask;

    for (genvar i = 0; i < DataWidth; i++) begin : g_mask
        assign bit_mask[i] = be_i[i / ByteWidth];
    end

    // Contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
        end
        if (req_i && !we_i) begin
            rdata_q[0] <= mem_q[addr_i];
        end
        for (int s = 1; s < Latency; s++) begin
            rdata_q[s] <= rdata_q[s-1];
        end
    end

    assign rdata_o = rdata_q[Latency-1];
endmodule

module axi_llc_sram_banked #(
    parameter int unsigned NumWords  = 256,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumBanks  = 4,
    parameter int unsigned Latency   = 2,
    parameter int unsigned RespDepth = 4,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 init_i,
    output logic                 busy_o,
    output logic                 init_done_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o
);
    localparam int unsigned BankBits  = $clog2(NumBanks);
    localparam int unsigned BankW     = (BankBits > 0) ? BankBits : 1;
    localparam int unsigned BankWords = NumWords / NumBanks;
    localparam int unsigned RowW      = (BankWords > 1) ? $clog2(BankWords) : 1;
    localparam int unsigned CntW      = $clog2(RespDepth + 1);
    localparam int unsigned PtrW      = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    typedef enum logic [1:0] {IDLE, INIT, DONE} state_e;

    state_e               state_q, state_d;
    logic [RowW-1:0]      row_q, row_d;
    logic [CntW-1:0]      outst_q, outst_d;
    logic [Latency-1:0]   pvld_q;
    logic [BankW-1:0]     pbank_q [Latency];
    logic [DataWidth-1:0] fifo_q  [RespDepth];
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [CntW-1:0]      fcnt_q;

    logic                 req_hs, rd_acc, rsp_hs, fifo_empty, fifo_push, fifo_pop, pipe_vld;
    logic [BankW-1:0]     req_bank;
    logic [RowW-1:0]      req_row;
    logic [DataWidth-1:0] pipe_rdata;
    logic [DataWidth-1:0] bank_rdata [NumBanks];
    logic [NumBanks-1:0]  bank_req;
    logic                 bank_we;
    logic [RowW-1:0]      bank_addr;
    logic [DataWidth-1:0] bank_wdata;
    logic [BeWidth-1:0]   bank_be;

    if (NumBanks > 1) begin : g_bank_sel
        assign req_bank = req_addr_i[BankBits-1:0];
    end else begin : g_single_bank
        assign req_bank = '0;
    end
    assign req_row = RowW'(req_addr_i >> BankBits);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        busy_o      = 1'b0;
        init_done_o = 1'b0;
        req_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = (outst_q < CntW'(RespDepth));
                if (init_i) begin
                    state_d = INIT;
                    row_d   = '0;
                end
            end
            INIT: begin
                busy_o = 1'b1;
                row_d  = row_q + 1'b1;
                if (row_q == RowW'(BankWords - 1)) state_d = DONE;
            end
            DONE: begin
                busy_o      = 1'b1;
                init_done_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_hs = req_valid_i && req_ready_o;
    assign rd_acc = req_hs && !req_we_i;

    // Init clears one row in every bank per cycle; otherwise only the addressed bank is touched.
    always_comb begin
        bank_req   = '0;
        bank_we    = req_we_i;
        bank_addr  = req_row;
        bank_wdata = req_wdata_i;
        bank_be    = req_be_i;
        if (state_q == INIT) begin
            bank_req   = '1;
            bank_we    = 1'b1;
            bank_addr  = row_q;
            bank_wdata = '0;
            bank_be    = '1;
        end else if (req_hs) begin
            bank_req[req_bank] = 1'b1;
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        tc_sram #(
            .NumWords (BankWords),
            .DataWidth(DataWidth),
            .ByteWidth(ByteWidth),
            .Latency  (Latency)
        ) i_sram (
            .clk_i  (clk_i),
            .req_i  (bank_req[b]),
            .we_i   (bank_we),
            .addr_i (bank_addr),
            .wdata_i(bank_wdata),
            .be_i   (bank_be),
            .rdata_o(bank_rdata[b])
        );
    end

    assign pipe_vld   = pvld_q[Latency-1];
    assign pipe_rdata = bank_rdata[pbank_q[Latency-1]];
    assign fifo_empty = (fcnt_q == '0);

    // Pipeline output bypasses the buffer when it is empty and the consumer is ready.
    assign rsp_valid_o = !fifo_empty || pipe_vld;
    assign rsp_rdata_o = fifo_empty ? pipe_rdata : fifo_q[rptr_q];
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;
    assign fifo_pop    = !fifo_empty && rsp_ready_i;
    assign fifo_push   = pipe_vld && !(fifo_empty && rsp_ready_i);

    always_comb begin
        outst_d = outst_q;
        case ({rd_acc, rsp_hs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            row_q   <= '0;
            outst_q <= '0;
            pvld_q  <= '0;
            for (int s = 0; s < Latency; s++) pbank_q[s] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            outst_q    <= outst_d;
            pvld_q[0]  <= rd_acc;
            pbank_q[0] <= req_bank;
            for (int s = 1; s < Latency; s++) begin
                pvld_q[s]  <= pvld_q[s-1];
                pbank_q[s] <= pbank_q[s-1];
            end
            if (fifo_push) wptr_q <= (wptr_q == PtrW'(RespDepth - 1)) ? '0 : wptr_q + 1'b1;
            if (fifo_pop)  rptr_q <= (rptr_q == PtrW'(RespDepth - 1)) ? '0 : rptr_q + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_q[wptr_q] <= pipe_rdata;
    end
endmodule

// File: doc/axi_llc_sram_banked.md
AXI_LLC_SRAM_BANKED -- requirements
Module: axi_llc_sram_banked

Interface
REQ-001: Parameter NumWords, default 256: total words; SHALL be a multiple of NumBanks.
REQ-002: Parameter DataWidth, default 64: word width in bits.
REQ-003: Parameter ByteWidth, default 8: byte-enable granularity; BeWidth = ceil(DataWidth/ByteWidth).
REQ-004: Parameter NumBanks, default 4: word-interleaved banks; SHALL be a power of two, at least 1.
REQ-005: Parameter Latency, default 2: SRAM read latency in cycles, at least 1; passed to each tc_sram bank.
REQ-006: Parameter RespDepth, default 4: response buffer depth; SHALL be at least Latency.
REQ-007: Ports SHALL be as follows; AddrWidth = max(1, clog2(NumWords)).
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- init_i  in  1  start zero-initialisation of all words
- busy_o  out  1  init sequence in progress
- init_done_o  out  1  one-cycle pulse when init completes
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  AddrWidth  word address
- req_wdata_i  in  DataWidth  write data
- req_be_i  in  BeWidth  write byte enables
- rsp_valid_o  out  1  read data valid
- rsp_ready_i  in  1  read data consumed when high with rsp_valid_o
- rsp_rdata_o  out  DataWidth  read data

Function
REQ-008: Bank index SHALL be req_addr_i[clog2(NumBanks)-1:0]; row SHALL be the remaining upper bits; with NumBanks = 1 the full address is the row.
REQ-009: Exactly one bank SHALL be enabled per accepted request; the other banks stay idle.
REQ-010: Writes SHALL update only bytes with req_be_i set, SHALL be posted, and SHALL generate no response.
REQ-011: Each read SHALL produce exactly one response, in acceptance order.
REQ-012: A read accepted in cycle t SHALL give rsp_valid_o no earlier than t+Latency; when the buffer is empty and rsp_ready_i is high, it SHALL give rsp_valid_o exactly at t+Latency (fall-through).
REQ-013: A Latency-deep valid/bank-index pipeline SHALL steer the matching bank's rdata into the RespDepth-entry response FIFO.
REQ-014: An outstanding counter SHALL track reads in flight plus FIFO entries.
- +1 on read accept; -1 on response handshake; unchanged when both occur in the same cycle.
REQ-015: req_ready_o SHALL be high only when the FSM is in IDLE and outstanding < RespDepth; the FIFO never overflows.
REQ-016: req_ready_o SHALL NOT depend on req_valid_i or req_we_i.
REQ-017: rsp_rdata_o SHALL stay stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-018: A read of an address in the cycle after a write to it SHALL return the written data.
REQ-019: The FSM SHALL have three states: IDLE, INIT, DONE.
REQ-020: In IDLE, init_i high SHALL move the FSM to INIT next cycle; a request accepted in that same cycle SHALL complete normally.
REQ-021: In INIT, the FSM SHALL write all-zero data with all byte enables to row r of every bank in parallel.
- r runs 0 .. NumWords/NumBanks-1, one row per cycle.
- After the last row the FSM moves to DONE.
REQ-022: DONE SHALL assert init_done_o for one cycle and then return to IDLE.
REQ-023: busy_o SHALL be high in INIT and DONE.
REQ-024: init_i SHALL be ignored outside IDLE.
REQ-025: Reads in flight when init starts SHALL still return their pre-init data and drain normally.
REQ-026: The row counter SHALL be wide enough for NumWords/NumBanks-1 and SHALL clear on entering INIT.

Reset
REQ-027: While rst_ni is low, and after it rises, the block SHALL hold:
- FSM in IDLE; outstanding, row counter and pipeline valid bits at 0; FIFO empty.
- rsp_valid_o = 0, busy_o = 0, init_done_o = 0.
- req_ready_o = 1 from the first cycle after reset release.
REQ-028: SRAM contents SHALL NOT be reset.
REQ-029: Reset asserted mid-read or mid-init SHALL abort all activity, with no response emitted afterwards.

Verification
REQ-030: Write 0x1122334455667788 to addr 5, all BE; read addr 5 with rsp_ready_i = 1 -> rsp_valid_o exactly 2 cycles after read accept, data 0x1122334455667788.
REQ-031: Write BE = 0x0F with data 0xFFFFFFFFFFFFFFFF over the previous value at addr 5; read -> 0x11223344FFFFFFFF.
REQ-032: rsp_ready_i = 0; issue back-to-back reads to addrs 0..7 -> exactly 4 accepted, then req_ready_o = 0 and rsp_rdata_o stable. Release rsp_ready_i -> all 8 returned in order, none lost or duplicated.
REQ-033: Pulse init_i in IDLE -> busy_o high for 64 INIT cycles + 1 DONE cycle, init_done_o pulses once, req_ready_o low throughout; afterwards reads of addrs 0, 1, 2, 3 and 255 return 0.
REQ-034: Issue a read of addr 9 (previously written with 0xAB), then assert init_i in the next cycle -> response 0xAB is still delivered; init completes normally.
REQ-035: Deassert rst_ni during INIT at row 10 -> busy_o = 0 and rsp_valid_o = 0 immediately; req_ready_o = 1 in the first cycle after release.
